switch_debounce: RTL and testbench

Conditions the 18 raw slide-switch inputs before they reach the switch PIO's 18-bit input port. Each bit is synchronised into the system clock domain, then debounced against a shared sample tick. The block drives the 18-bit debounced word into the PIO input port, plus single-cycle rise/fall strobes for optional edge consumers such as the time-set logic.

---
 rtl/switch_debounce_pkg.sv | 23 ++
 rtl/debounce_bit.sv | 70 +++++++
 rtl/switch_debounce.sv | 55 +++++
 tb/tb_switch_debounce.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared constants and width helper for the slide-switch conditioning block.
// Latency: n/a (elaboration-time constants only).
// Backpressure: n/a.
package switch_debounce_pkg;

    localparam int SW_WIDTH               = 18;
    localparam int DEFAULT_TICK_DIV       = 50000;
    localparam int DEFAULT_STABLE_SAMPLES = 10;

    // Bits needed to hold values 0..value-1; used to size the counters.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-FF synchroniser, tick-qualified stability counter, level and edge strobes.
// Latency: 2 clk sync plus STABLE_SAMPLES mismatching ticks before sw_db follows the pin.
// Backpressure: none; the pin is sampled every clk and strobes are fire-and-forget.
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int   STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
    parameter logic RESET_VALUE    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_tick,
    input  logic sw_raw,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int             CW       = clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_SAMPLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          mismatch;
    logic          accept;

    // The new level is taken on the tick that completes the run of mismatching samples.
    assign mismatch = sync2 ^ sw_db;
    assign accept   = mismatch & sample_tick & (cnt == CNT_LAST);

    // Plain two-flop chain into the clk domain; nothing may sit between the stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Count mismatching ticks; any return to the current level or an accept restarts the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!mismatch || accept) begin
            cnt <= '0;
        end else if (sample_tick) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Update the debounced level and raise the matching edge strobe for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_db   <= RESET_VALUE;
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
        end else begin
            sw_rise <= accept & sync2;
            sw_fall <= accept & ~sync2;
            if (accept) begin
                sw_db <= sync2;
            end
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Synchronises and debounces the slide switches feeding the switch PIO, with per-bit edge strobes.
// Latency: 2 clk plus STABLE_SAMPLES sample ticks from a clean pin change to sw_db/strobe.
// Backpressure: none; outputs are free-running levels and one-cycle strobes.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int               WIDTH          = SW_WIDTH,
    parameter int               TICK_DIV       = DEFAULT_TICK_DIV,      // >= 2
    parameter int               STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES, // >= 1
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sample_tick
);

    localparam int            TW        = clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_DIV - 2);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic [TW-1:0] tick_cnt;

    // Shared prescaler; the tick register is loaded one count early so it is high
    // during the cycle in which the counter wraps, first time TICK_DIV cycles after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt    <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= (tick_cnt == TICK_PRE);
            tick_cnt    <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_ONE;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .RESET_VALUE    (RESET_VALUE[i])
        ) u_bit (
            .clk         (clk),
            .reset       (reset),
            .sample_tick (sample_tick),
            .sw_raw      (sw_raw[i]),
            .sw_db       (sw_db[i]),
            .sw_rise     (sw_rise[i]),
            .sw_fall     (sw_fall[i])
        );
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: two instances (main and parameter-corner configuration).
// Expected edge events are queued when pins change and matched when strobes fire.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_switch_debounce;

    typedef struct {
        int          cyc;
        logic [17:0] rise;
        logic [17:0] fall;
        logic [17:0] db;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [17:0] raw_a, raw_b;
    logic [17:0] db_a, rise_a, fall_a;
    logic [17:0] db_b, rise_b, fall_b;
    logic        tick_a, tick_b;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          ra    = 0;
    int          rb    = 0;
    logic        rst_q_a = 1'b1;
    logic        rst_q_b = 1'b1;
    logic [17:0] db_exp_a = '0;
    logic [17:0] db_exp_b = 18'h2AAAA;
    ev_t         q_a[$];
    ev_t         q_b[$];
    ev_t         e_a, e_b;

    always #5 clk = ~clk;

    switch_debounce #(
        .WIDTH(18), .TICK_DIV(4), .STABLE_SAMPLES(3), .RESET_VALUE(18'h0)
    ) dut_a (
        .clk(clk), .reset(rst_a), .sw_raw(raw_a), .sw_db(db_a),
        .sw_rise(rise_a), .sw_fall(fall_a), .sample_tick(tick_a)
    );

    switch_debounce #(
        .WIDTH(18), .TICK_DIV(2), .STABLE_SAMPLES(1), .RESET_VALUE(18'h2AAAA)
    ) dut_b (
        .clk(clk), .reset(rst_b), .sw_raw(raw_b), .sw_db(db_b),
        .sw_rise(rise_b), .sw_fall(fall_b), .sample_tick(tick_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Cycle in which sw_db/strobe should show the new level: the synchronised mismatch
    // is first seen in cycle 'start'; ticks are visible at r+td-1, r+2td-1, ...
    function automatic int ev_cycle(input int start, input int r, input int td, input int ss);
        int t;
        t = r + td - 1;
        while (t < start) t += td;
        return t + (ss - 1) * td + 1;
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q_a.size() + q_b.size()) != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if ((q_a.size() + q_b.size()) != 0) begin
            chk("drain_timeout", q_a.size() + q_b.size(), 0);
            q_a.delete();
            q_b.delete();
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Cycle counter and record of the last cycle each DUT was held in reset.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_q_a <= rst_a;
        rst_q_b <= rst_b;
        if (rst_a) ra <= cyc + 1;
        if (rst_b) rb <= cyc + 1;
    end

    // Monitor for the main instance.
    always @(negedge clk) begin
        if (rst_q_a) begin
            chk("a_rst_db",   db_a,   18'h0);
            chk("a_rst_rise", rise_a, 18'h0);
            chk("a_rst_fall", fall_a, 18'h0);
            chk("a_rst_tick", tick_a, 1'b0);
            db_exp_a <= 18'h0;
        end else begin
            chk("a_tick", tick_a, ((cyc - ra) % 4) == 3);
            if ((rise_a | fall_a) != 18'h0) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_edge", rise_a | fall_a, 18'h0);
                end else begin
                    e_a = q_a.pop_front();
                    chk("a_edge_cycle", cyc, e_a.cyc);
                    chk("a_rise", rise_a, e_a.rise);
                    chk("a_fall", fall_a, e_a.fall);
                    chk("a_db_new", db_a, e_a.db);
                    db_exp_a <= e_a.db;
                end
            end else begin
                chk("a_db_hold", db_a, db_exp_a);
            end
        end
    end

    // Monitor for the parameter-corner instance.
    always @(negedge clk) begin
        if (rst_q_b) begin
            chk("b_rst_db",   db_b,   18'h2AAAA);
            chk("b_rst_rise", rise_b, 18'h0);
            chk("b_rst_fall", fall_b, 18'h0);
            chk("b_rst_tick", tick_b, 1'b0);
            db_exp_b <= 18'h2AAAA;
        end else begin
            chk("b_tick", tick_b, ((cyc - rb) % 2) == 1);
            if ((rise_b | fall_b) != 18'h0) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_edge", rise_b | fall_b, 18'h0);
                end else begin
                    e_b = q_b.pop_front();
                    chk("b_edge_cycle", cyc, e_b.cyc);
                    chk("b_rise", rise_b, e_b.rise);
                    chk("b_fall", fall_b, e_b.fall);
                    chk("b_db_new", db_b, e_b.db);
                    db_exp_b <= e_b.db;
                end
            end else begin
                chk("b_db_hold", db_b, db_exp_b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        int t2;
        rst_a = 1'b1;
        raw_a = 18'h3FFFF;
        rst_b = 1'b1;
        raw_b = 18'h0;

        // 1. Reset with all pins high; release with pins low. Tick timing checked by monitor.
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        raw_a = 18'h0;
        wait_cyc(cyc + 6);

        // 2. Clean rise on bit 5.
        p = cyc;
        raw_a[5] = 1'b1;
        q_a.push_back('{ev_cycle(p + 2, ra, 4, 3), 18'h00020, 18'h0, 18'h00020});
        drain(100);

        // 3. Bounce on bit 0: high 2 ticks, low 1 tick, then high.
        p = cyc;
        raw_a[0] = 1'b1;
        wait_cyc(p + 8);
        raw_a[0] = 1'b0;
        wait_cyc(p + 12);
        raw_a[0] = 1'b1;
        q_a.push_back('{ev_cycle(p + 14, ra, 4, 3), 18'h00001, 18'h0, 18'h00021});
        drain(100);

        // 4a. Move to sw_db = 3: bit 1 rises and bit 5 falls together.
        p = cyc;
        raw_a[5] = 1'b0;
        raw_a[1] = 1'b1;
        q_a.push_back('{ev_cycle(p + 2, ra, 4, 3), 18'h00002, 18'h00020, 18'h00003});
        drain(100);

        // 4b. Drop bits 0 and 1 in the same cycle.
        p = cyc;
        raw_a[1:0] = 2'b00;
        q_a.push_back('{ev_cycle(p + 2, ra, 4, 3), 18'h0, 18'h00003, 18'h0});
        drain(100);

        // 5. Raise bit 17, reset after its second counted tick, then a full new run.
        p = cyc;
        raw_a[17] = 1'b1;
        t2 = ev_cycle(p + 2, ra, 4, 1) - 1 + 4;
        wait_cyc(t2 + 1);
        rst_a = 1'b1;
        wait_cyc(cyc + 2);
        rst_a = 1'b0;
        q_a.push_back('{ev_cycle(cyc + 2, ra, 4, 3), 18'h20000, 18'h0, 18'h20000});
        drain(100);

        // 6. Corner configuration: single-sample acceptance, two-cycle tick.
        wait_cyc(cyc + 1);
        rst_b = 1'b0;
        q_b.push_back('{ev_cycle(cyc, rb, 2, 1), 18'h0, 18'h2AAAA, 18'h0});
        drain(50);
        p = cyc;
        raw_b = 18'h3FFFF;
        q_b.push_back('{ev_cycle(p + 2, rb, 2, 1), 18'h3FFFF, 18'h0, 18'h3FFFF});
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
